// File: rtl/char_nibble_tx.sv
// Nibble-link transmitter: buffers 8-bit characters in a small FIFO and sends
// each one as two strobed nibbles, high nibble first, with startFlag marking the high half.
module char_nibble_tx #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic [7:0]                   charIn,
  input  logic                         charValid,
  output logic                         charReady,
  output logic [3:0]                   dataOut,
  output logic                         readFlag,
  output logic                         startFlag,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifoLevel
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned MAX_SG  = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_CYC = (STROBE_CYCLES > MAX_SG) ? STROBE_CYCLES : MAX_SG;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP_HI,
    STROBE_HI,
    GAP_HI,
    SETUP_LO,
    STROBE_LO,
    GAP_LO
  } state_t;

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [7:0]       headChar;
  logic [3:0]       loNibble;
  logic [CNT_W-1:0] cnt;
  logic             pushC;
  logic             popC;
  logic             haveChar;
  logic             cntDone;

  // Ready comes from the pre-edge level, so a pop never makes room for a same-edge push.
  assign charReady = (fifoLevel != LVL_W'(FIFO_DEPTH));
  assign pushC     = charValid && charReady;
  assign haveChar  = (fifoLevel != '0);
  assign cntDone   = (cnt == '0);
  assign popC      = haveChar && ((state == IDLE) || ((state == GAP_LO) && cntDone));
  assign headChar  = mem[rdPtr];

  // Character storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (pushC) begin
      mem[wrPtr] <= charIn;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoLevel <= '0;
    end else begin
      if (pushC) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (popC) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({pushC, popC})
        2'b10:   fifoLevel <= fifoLevel + 1'b1;
        2'b01:   fifoLevel <= fifoLevel - 1'b1;
        default: fifoLevel <= fifoLevel;
      endcase
    end
  end

  // Link sequencer; a pop always starts a fresh character in SETUP_HI.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      cnt       <= '0;
      loNibble  <= '0;
      dataOut   <= '0;
      readFlag  <= 1'b0;
      startFlag <= 1'b0;
      busy      <= 1'b0;
    end else if (popC) begin
      state     <= SETUP_HI;
      cnt       <= SETUP_LD;
      dataOut   <= headChar[7:4];
      loNibble  <= headChar[3:0];
      startFlag <= 1'b1;
      readFlag  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          dataOut   <= '0;
          startFlag <= 1'b0;
          busy      <= 1'b0;
        end
        SETUP_HI, SETUP_LO: begin
          if (cntDone) begin
            state    <= (state == SETUP_HI) ? STROBE_HI : STROBE_LO;
            cnt      <= STROBE_LD;
            readFlag <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE_HI, STROBE_LO: begin
          if (cntDone) begin
            state    <= (state == STROBE_HI) ? GAP_HI : GAP_LO;
            cnt      <= GAP_LD;
            readFlag <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP_HI: begin
          if (cntDone) begin
            state     <= SETUP_LO;
            cnt       <= SETUP_LD;
            dataOut   <= loNibble;
            startFlag <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP_LO: begin
          if (cntDone) begin
            state     <= IDLE;
            dataOut   <= '0;
            startFlag <= 1'b0;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          readFlag <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_nibble_tx.sv
// Bench for char_nibble_tx: character-level reference model with a receiver
// scoreboard on the default build, plus a vector table for an all-ones timing build.
`timescale 1ns/1ps
module tb_char_nibble_tx;

  localparam int DEPTH = 4;
  localparam int S     = 1;
  localparam int ST    = 2;
  localparam int G     = 2;
  localparam int H     = S + ST + G;
  localparam int P     = 2 * H;

  logic       clk = 1'b0;
  logic       rstN, rstN1;
  logic [7:0] charIn, charIn1;
  logic       charValid, charValid1;
  logic       charReady, charReady1;
  logic [3:0] dataOut, dataOut1;
  logic       readFlag, readFlag1;
  logic       startFlag, startFlag1;
  logic       busy, busy1;
  logic [2:0] fifoLevel;
  logic [1:0] fifoLevel1;

  always #5 clk = ~clk;

  char_nibble_tx dut (
    .clk(clk), .rstN(rstN), .charIn(charIn), .charValid(charValid),
    .charReady(charReady), .dataOut(dataOut), .readFlag(readFlag),
    .startFlag(startFlag), .busy(busy), .fifoLevel(fifoLevel)
  );

  char_nibble_tx #(.FIFO_DEPTH(2), .SETUP_CYCLES(1), .STROBE_CYCLES(1), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .rstN(rstN1), .charIn(charIn1), .charValid(charValid1),
    .charReady(charReady1), .dataOut(dataOut1), .readFlag(readFlag1),
    .startFlag(startFlag1), .busy(busy1), .fifoLevel(fifoLevel1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of buffered characters and the start edge of the one on the link.
  logic [7:0] mq[$];
  logic [7:0] expQ[$];
  logic [7:0] mChar;
  bit         mActive;
  int         mStart;
  int         cyc;
  int         riseQ[$];
  bit         prevRf;
  int         rxCount = 0;

  task automatic modelReset();
    mq.delete();
    expQ.delete();
    riseQ.delete();
    mActive = 0;
    mStart  = 0;
    cyc     = 0;
    prevRf  = 0;
  endtask

  task automatic modelEdge(input logic v, input logic [7:0] c);
    bit acc;
    acc = v && (mq.size() < DEPTH);
    cyc++;
    if (!mActive || (cyc - mStart) == P) begin
      if (mq.size() > 0) begin
        mChar   = mq.pop_front();
        mStart  = cyc;
        mActive = 1;
      end else begin
        mActive = 0;
      end
    end
    if (acc) begin
      mq.push_back(c);
      expQ.push_back(c);
    end
  endtask

  task automatic checkModel();
    logic [3:0] eD;
    logic       eRf, eSf, eBz;
    int         t, u;
    eD = 4'h0; eRf = 1'b0; eSf = 1'b0; eBz = 1'b0;
    if (mActive) begin
      t   = cyc - mStart;
      u   = (t < H) ? t : t - H;
      eD  = (t < H) ? mChar[7:4] : mChar[3:0];
      eSf = (t < H);
      eRf = (u >= S) && (u < S + ST);
      eBz = 1'b1;
    end
    chk("dataOut",   32'(dataOut),   32'(eD));
    chk("readFlag",  32'(readFlag),  32'(eRf));
    chk("startFlag", 32'(startFlag), 32'(eSf));
    chk("busy",      32'(busy),      32'(eBz));
    chk("fifoLevel", 32'(fifoLevel), 32'(mq.size()));
    chk("charReady", 32'(charReady), 32'(mq.size() < DEPTH));
  endtask

  task automatic tick(input logic v, input logic [7:0] c);
    charValid = v;
    charIn    = c;
    @(posedge clk);
    modelEdge(v, c);
    #1;
    checkModel();
    if (readFlag && !prevRf) riseQ.push_back(cyc);
    prevRf = readFlag;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (!mActive && mq.size() == 0) break;
      tick(1'b0, 8'h00);
    end
    chk("drain_done", 32'(mActive || mq.size() != 0), 32'd0);
    chk("rx_pending", 32'(expQ.size()), 32'd0);
  endtask

  // Receiver: reassembles a character on each readFlag rise; LEDs show its two low bits.
  logic [3:0] rxHi = 4'h0;
  logic [7:0] rxChar;
  logic       led1 = 1'b0, led2 = 1'b0;

  always @(posedge readFlag) begin
    if (startFlag) begin
      rxHi = dataOut;
    end else begin
      rxChar = {rxHi, dataOut};
      led1   = rxChar[1];
      led2   = rxChar[0];
      rxCount++;
      if (expQ.size() == 0) chk("rx_extra", 32'(rxChar), 32'hFFFF_FFFF);
      else chk("rx_char", 32'(rxChar), 32'(expQ.pop_front()));
    end
  end

  typedef struct {
    logic       v;
    logic [7:0] c;
    logic [3:0] d;
    logic       rf;
    logic       sf;
    logic       bz;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int pe, rx0;
    logic [7:0] fillChars [5];

    // All-ones timing: push FF then 00, one strobe every 3 cycles.
    tbl[0]  = '{1'b1, 8'hFF, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'h00, 4'hF, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 4'hF, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 4'hF, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 4'hF, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 4'hF, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 4'hF, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0};

    fillChars[0] = 8'h57; fillChars[1] = 8'h58; fillChars[2] = 8'h59;
    fillChars[3] = 8'h5A; fillChars[4] = 8'h56;

    rstN = 1'b0; rstN1 = 1'b0;
    charValid = 1'b0; charIn = 8'h00;
    charValid1 = 1'b0; charIn1 = 8'h00;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dataOut",   32'(dataOut),   32'd0);
    chk("rst_readFlag",  32'(readFlag),  32'd0);
    chk("rst_startFlag", 32'(startFlag), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_fifoLevel", 32'(fifoLevel), 32'd0);
    chk("rst_charReady", 32'(charReady), 32'd1);
    rstN = 1'b1; rstN1 = 1'b1;

    for (int i = 0; i < 15; i++) begin
      charValid1 = tbl[i].v;
      charIn1    = tbl[i].c;
      @(posedge clk);
      #1;
      chk($sformatf("t1_dataOut[%0d]", i),   32'(dataOut1),   32'(tbl[i].d));
      chk($sformatf("t1_readFlag[%0d]", i),  32'(readFlag1),  32'(tbl[i].rf));
      chk($sformatf("t1_startFlag[%0d]", i), 32'(startFlag1), 32'(tbl[i].sf));
      chk($sformatf("t1_busy[%0d]", i),      32'(busy1),      32'(tbl[i].bz));
    end
    charValid1 = 1'b0;

    // Single 'A': strobes two and seven edges after the push edge.
    riseQ.delete();
    tick(1'b1, 8'h41);
    pe = cyc;
    drain();
    chk("A_rises", 32'(riseQ.size()), 32'd2);
    if (riseQ.size() == 2) begin
      chk("A_rise_hi", 32'(riseQ[0] - pe), 32'd2);
      chk("A_rise_lo", 32'(riseQ[1] - pe), 32'd7);
    end
    chk("A_led1", 32'(led1), 32'd0);
    chk("A_led2", 32'(led2), 32'd1);

    // Back-to-back 'A','B','C': strobes every 5 cycles with no idle gap.
    riseQ.delete();
    tick(1'b1, 8'h41);
    pe = cyc;
    tick(1'b1, 8'h42);
    tick(1'b1, 8'h43);
    drain();
    chk("ABC_rises", 32'(riseQ.size()), 32'd6);
    if (riseQ.size() == 6) begin
      chk("ABC_first", 32'(riseQ[0] - pe), 32'd2);
      for (int i = 1; i < 6; i++) chk($sformatf("ABC_period[%0d]", i), 32'(riseQ[i] - riseQ[i-1]), 32'd5);
    end
    chk("ABC_led1", 32'(led1), 32'd1);
    chk("ABC_led2", 32'(led2), 32'd1);

    // Fill to full while transmitting, drop one push, then push on a pop edge at level 3.
    rx0 = rxCount;
    for (int i = 0; i < 5; i++) tick(1'b1, fillChars[i]);
    chk("full_level", 32'(fifoLevel), 32'd4);
    chk("full_ready", 32'(charReady), 32'd0);
    tick(1'b1, 8'h55);
    chk("drop_level", 32'(fifoLevel), 32'd4);
    repeat (15) tick(1'b0, 8'h00);
    chk("pre_pp_level", 32'(fifoLevel), 32'd3);
    tick(1'b1, 8'h54);
    chk("pp_level", 32'(fifoLevel), 32'd3);
    drain();
    chk("fill_rx_count", 32'(rxCount - rx0), 32'd6);

    // Asynchronous reset during the low-nibble strobe with two characters buffered.
    tick(1'b1, 8'h41);
    tick(1'b1, 8'h42);
    tick(1'b1, 8'h43);
    repeat (5) tick(1'b0, 8'h00);
    chk("pre_rst_readFlag", 32'(readFlag), 32'd1);
    chk("pre_rst_level",    32'(fifoLevel), 32'd2);
    #2 rstN = 1'b0;
    #1;
    chk("arst_readFlag",  32'(readFlag),  32'd0);
    chk("arst_dataOut",   32'(dataOut),   32'd0);
    chk("arst_startFlag", 32'(startFlag), 32'd0);
    chk("arst_fifoLevel", 32'(fifoLevel), 32'd0);
    chk("arst_busy",      32'(busy),      32'd0);
    #1 rstN = 1'b1;
    modelReset();
    repeat (20) tick(1'b0, 8'h00);
    chk("post_rst_rises", 32'(riseQ.size()), 32'd0);

    // Random traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0, 8'($urandom));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
